// File: rtl/and_gate.sv
// Bitwise AND leaf cell: combinational y = a & b, plus a registered copy and
// saturating activity counters for the all-ones (match) condition.
module and_gate #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned CNT_W = 16
) (
  output logic [WIDTH-1:0] y,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  output logic [WIDTH-1:0] y_q,
  output logic             match_q,
  output logic [CNT_W-1:0] rise_cnt,
  output logic [CNT_W-1:0] high_cnt
);

  localparam logic [CNT_W-1:0] CntMax = '1;
  localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

  logic             match;
  logic             rise;
  logic [CNT_W-1:0] rise_cnt_d;
  logic [CNT_W-1:0] high_cnt_d;

  // Kept free of clk/rst/clr so a positional (y, a, b) hookup still works.
  assign y     = a & b;
  assign match = &y;
  assign rise  = match & ~match_q;

  always_comb begin
    rise_cnt_d = rise_cnt;
    high_cnt_d = high_cnt;
    if (clr) begin
      rise_cnt_d = '0;
      high_cnt_d = '0;
    end else begin
      if (rise && rise_cnt != CntMax) begin
        rise_cnt_d = rise_cnt + CntOne;
      end
      if (match && high_cnt != CntMax) begin
        high_cnt_d = high_cnt + CntOne;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_q      <= '0;
      match_q  <= 1'b0;
      rise_cnt <= '0;
      high_cnt <= '0;
    end else begin
      y_q      <= y;
      match_q  <= match;
      rise_cnt <= rise_cnt_d;
      high_cnt <= high_cnt_d;
    end
  end

endmodule

// File: tb/tb_and_gate.sv
// Directed self-checking bench for and_gate: truth table, async reset,
// counting, saturation, clear priority and a 4-bit instance.
module tb_and_gate;

  logic clk = 1'b0;
  logic clk_en = 1'b0;
  logic rst = 1'b0;
  logic clr = 1'b0;

  // WIDTH=1, CNT_W=16
  logic        a1 = 1'b0, b1 = 1'b0;
  logic        y1, yq1, mq1;
  logic [15:0] rc1, hc1;
  // WIDTH=1, CNT_W=2
  logic        as = 1'b0, bs = 1'b0;
  logic        ys, yqs, mqs;
  logic [1:0]  rcs, hcs;
  // WIDTH=4, CNT_W=16
  logic [3:0]  a4 = 4'h0, b4 = 4'h0;
  logic [3:0]  y4, yq4;
  logic        mq4;
  logic [15:0] rc4, hc4;

  int n_cmp = 0;
  int n_fail = 0;

  and_gate #(.WIDTH(1), .CNT_W(16)) u_w1 (
    .y(y1), .a(a1), .b(b1), .clk(clk), .rst(rst), .clr(clr),
    .y_q(yq1), .match_q(mq1), .rise_cnt(rc1), .high_cnt(hc1)
  );

  and_gate #(.WIDTH(1), .CNT_W(2)) u_sat (
    .y(ys), .a(as), .b(bs), .clk(clk), .rst(rst), .clr(clr),
    .y_q(yqs), .match_q(mqs), .rise_cnt(rcs), .high_cnt(hcs)
  );

  and_gate #(.WIDTH(4), .CNT_W(16)) u_w4 (
    .y(y4), .a(a4), .b(b4), .clk(clk), .rst(rst), .clr(clr),
    .y_q(yq4), .match_q(mq4), .rise_cnt(rc4), .high_cnt(hc4)
  );

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Rising edge, then settle 1 time unit before sampling/driving.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    #1;
    rst = 1'b0;
  endtask

  initial begin
    // Truth table with no clock running and reset idle.
    a1 = 0; b1 = 0; #10; check("tt_00", 32'(y1), 32'd0);
    a1 = 0; b1 = 1; #10; check("tt_01", 32'(y1), 32'd0);
    a1 = 1; b1 = 0; #10; check("tt_10", 32'(y1), 32'd0);
    a1 = 1; b1 = 1; #10; check("tt_11", 32'(y1), 32'd1);
    a4 = 4'b1111; b4 = 4'b1010; #10; check("tt_w4", 32'(y4), 32'ha);
    a4 = 4'h0; b4 = 4'h0;

    // Async reset with a=b=1, no clock edge.
    rst = 1'b1;
    #1;
    check("rst_y",    32'(y1),  32'd1);
    check("rst_yq",   32'(yq1), 32'd0);
    check("rst_mq",   32'(mq1), 32'd0);
    check("rst_rise", 32'(rc1), 32'd0);
    check("rst_high", 32'(hc1), 32'd0);

    // Registers hold 0 while reset stays high under a running clock.
    clk_en = 1'b1;
    tick(2);
    check("rst_hold_high", 32'(hc1), 32'd0);
    check("rst_hold_yq",   32'(yq1), 32'd0);
    rst = 1'b0;

    // Counting: a=b=1 for 3 edges, a=0 for 2, a=1 for 1.
    tick(1);
    check("cnt1_yq",   32'(yq1), 32'd1);
    check("cnt1_rise", 32'(rc1), 32'd1);
    check("cnt1_high", 32'(hc1), 32'd1);
    tick(2);
    check("cnt3_high", 32'(hc1), 32'd3);
    a1 = 1'b0;
    #1;
    check("lag_y",  32'(y1),  32'd0);
    check("lag_yq", 32'(yq1), 32'd1);
    tick(2);
    check("cnt5_yq",   32'(yq1), 32'd0);
    check("cnt5_high", 32'(hc1), 32'd3);
    a1 = 1'b1;
    tick(1);
    check("cnt6_rise", 32'(rc1), 32'd2);
    check("cnt6_high", 32'(hc1), 32'd4);
    check("cnt6_mq",   32'(mq1), 32'd1);

    // Mid-count reset clears without waiting for a clock edge.
    #2;
    rst = 1'b1;
    #1;
    check("midrst_rise", 32'(rc1), 32'd0);
    check("midrst_high", 32'(hc1), 32'd0);
    // clr together with rst: rst dominates and registers stay 0.
    clr = 1'b1;
    tick(1);
    check("rstclr_mq", 32'(mq1), 32'd0);
    clr = 1'b0;
    rst = 1'b0;
    a1 = 1'b0; b1 = 1'b0;

    // Saturation at CNT_W=2.
    pulse_rst();
    as = 1'b1; bs = 1'b1;
    tick(3);
    check("sat3_high", 32'(hcs), 32'd3);
    tick(3);
    check("sat6_high", 32'(hcs), 32'd3);
    check("sat6_rise", 32'(rcs), 32'd1);
    as = 1'b0; bs = 1'b0;

    // clr wins over a match rise in the same cycle.
    pulse_rst();
    b1 = 1'b1;
    tick(1);
    check("clr_pre_mq", 32'(mq1), 32'd0);
    a1 = 1'b1; clr = 1'b1;
    tick(1);
    check("clr_rise", 32'(rc1), 32'd0);
    check("clr_high", 32'(hc1), 32'd0);
    check("clr_mq",   32'(mq1), 32'd1);
    clr = 1'b0;
    tick(1);
    check("postclr_high", 32'(hc1), 32'd1);
    check("postclr_rise", 32'(rc1), 32'd0);
    a1 = 1'b0; b1 = 1'b0;

    // WIDTH=4: partial mask does not match; full mask does.
    pulse_rst();
    a4 = 4'b1111; b4 = 4'b1011;
    #1;
    check("w4_y_part", 32'(y4), 32'hb);
    tick(1);
    check("w4_yq_part", 32'(yq4), 32'hb);
    check("w4_mq_part", 32'(mq4), 32'd0);
    check("w4_hc_part", 32'(hc4), 32'd0);
    b4 = 4'hf;
    #1;
    check("w4_y_full", 32'(y4), 32'hf);
    check("w4_hc_nochg", 32'(hc4), 32'd0);
    tick(1);
    check("w4_hc_1", 32'(hc4), 32'd1);
    check("w4_rc_1", 32'(rc4), 32'd1);
    tick(1);
    check("w4_hc_2", 32'(hc4), 32'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: observed no finish expected finish");
    $fatal(1);
  end

endmodule

// File: doc/and_gate.md
# and_gate

Bitwise AND primitive with a registered monitoring side-path. The combinational output `y = a & b` is available with zero latency and does not depend on clock or reset. A clocked section registers the result and counts assertions of the all-ones condition for observability. It is used as a leaf cell wherever a gated enable or mask is needed alongside cheap activity statistics.

## Interface
- `WIDTH`, 1: bit width of `a`, `b`, `y`, `y_q`.
- `CNT_W`, 16: width of both event counters.

Port declaration order is `y, a, b, clk, rst, clr, y_q, match_q, rise_cnt, high_cnt`. This order is fixed so that a positional `(y, a, b)` hookup works with the clocked ports left unconnected.

- `clk`  in  1: single clock. All registers update on its rising edge.
- `rst`  in  1: asynchronous, active-high reset for all registers.
- `y`  out  WIDTH: combinational `a & b`, bitwise.
- `a`  in  WIDTH: operand A.
- `b`  in  WIDTH: operand B.
- `clr`  in  1: synchronous clear of `rise_cnt` and `high_cnt`.
- `y_q`  out  WIDTH: `y` registered once.
- `match_q`  out  1: registered `&y`, i.e. all bits of `y` are high.
- `rise_cnt`  out  CNT_W: number of 0→1 transitions of `match`, saturating.
- `high_cnt`  out  CNT_W: number of clock cycles with `match` = 1, saturating.

## Operation
- `y = a & b` is purely combinational. It has no dependence on `clk`, `rst` or `clr`, and it stays correct even when `clk` and `rst` are unconnected.
- `match = &y` is an internal combinational signal. With `WIDTH=1`, `match` equals `y`.
- Each rising `clk` edge, when not in reset:
  - `y_q <= y`.
  - `match_q <= match`.
  - If `clr`: `rise_cnt <= 0` and `high_cnt <= 0`. `clr` takes priority over any event in the same cycle.
  - Otherwise:
    - If `match & ~match_q`, `rise_cnt` increments by 1.
    - If `match`, `high_cnt` increments by 1.
    - Both counters saturate at 2^CNT_W−1: hold at maximum and never wrap.
- `clr` does not affect `y_q` or `match_q`.
- Reset (`rst`=1, asynchronous assert) forces:
  - `y_q` = 0.
  - `match_q` = 0.
  - `rise_cnt` = 0.
  - `high_cnt` = 0.
- While `rst` is held, the registers stay 0. `y` still follows `a & b`.
- Reset deassertion takes effect at the next rising edge.
- Because `match_q` is 0 out of reset, `match` already high at the first clock counts as a rise.
- Inputs containing X/Z propagate per standard `&` semantics. No masking is applied.

## Timing
- `y`: zero-cycle combinational path from `a` and `b`.
- `y_q` and `match_q`: 1-cycle latency, valid after the edge that samples the input.
- Counters: updated at the same edge that updates `match_q`. The new count is visible after that edge.
- Reset asserted mid-count: counters clear immediately (asynchronous), with no wait for `clk`.
- `clr` and `rst` together: `rst` dominates.
- No handshake. `a` and `b` may change at any time. Only their values at each rising edge affect the registered outputs.

## Test plan
- Truth table, clock and reset unconnected, 10 time units per vector: `a,b` = 00, 01, 10, 11 -> `y` = 0, 0, 0, 1, settled within each interval.
- Reset check: assert `rst` with `a=b=1` -> `y`=1, while `y_q`=0, `match_q`=0, `rise_cnt`=0 and `high_cnt`=0 without any clock edge.
- Counting: `WIDTH=1`, hold `a=b=1` for 3 cycles, then `a=0` for 2 cycles, then `a=1` for 1 cycle -> `rise_cnt`=2, `high_cnt`=4, with `y_q` lagging `y` by one cycle.
- Saturation: `CNT_W=2`, `match` held high for 6 cycles -> `high_cnt` stops at 3 and `rise_cnt`=1.
- Clear priority: assert `clr` on a cycle where `match` rises -> both counters are 0 after that edge. The next cycle with `match` high gives `high_cnt`=1 and `rise_cnt`=0.
- `WIDTH=4`: `a=4'b1111`, `b=4'b1011` -> `y=4'b1011` and `match`=0 (`high_cnt` does not increment). Then `b=4'hF` -> `y=4'hF` and `high_cnt` increments from the next edge.
